// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave. spi_clk, spi_cs_n and mosi are
// oversampled on clk_i through SYNC_STAGES flops, and edges are found on the
// synchronised copies. All four CPOL/CPHA modes are supported. The word width
// and bit order are set by parameters.
//
// Ports:
//   clk_i, rst_i          system clock, synchronous active-high reset
//   spi_clk_i, spi_cs_n_i asynchronous SPI clock and chip select (active low)
//   mosi_i / miso_o       master-out / slave-out serial data
//   tx_data_i, tx_valid_i one-word transmit holding register write port
//   tx_ready_o            holding register empty
//   rx_data_o, rx_valid_o last received word, plus a one-cycle update strobe
//   busy_o                frame active (synchronised cs_n low)
//   underrun_o            one-cycle pulse: word loaded with no data in holding
module spi_slave_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  underrun_o
);
    localparam int   CW       = $clog2(DATA_WIDTH + 1);
    localparam logic IDLE_LVL = (CPOL != 0);

    typedef enum logic {IDLE, ACTIVE} state_e;

    // Synchronisers: index 0 is the first stage, SYNC_STAGES-1 is the last.
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, cs_dly_q;

    // The cs_n chain resets to "asserted". This stops a frame that is still
    // active through reset from looking like a new falling edge. The slave
    // only re-arms after cs_n has gone high and then low again.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= {SYNC_STAGES{IDLE_LVL}};
            sclk_dly_q  <= IDLE_LVL;
            cs_sync_q   <= '0;
            cs_dly_q    <= 1'b0;
            mosi_sync_q <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, mosi_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign lead_edge   = (sclk_s != sclk_dly_q) && (sclk_dly_q == IDLE_LVL);
    assign trail_edge  = (sclk_s != sclk_dly_q) && (sclk_s == IDLE_LVL);
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    assign cs_fall     = cs_dly_q & ~cs_s;
    assign cs_rise     = ~cs_dly_q & cs_s;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shin_q, shout_q, hold_q, rx_data_q;
    logic [DATA_WIDTH-1:0] shin_d, shout_d;
    logic [CW-1:0]         cnt_q;
    logic                  hold_full_q, load_pend_q, skip_q, rx_valid_q, underrun_q;
    logic                  do_load;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shin_d  = {shin_q[DATA_WIDTH-2:0], mosi_s};
            shout_d = {shout_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
            shin_d  = {mosi_s, shin_q[DATA_WIDTH-1:1]};
            shout_d = {1'b0, shout_q[DATA_WIDTH-1:1]};
        end
        // A word is loaded when a frame starts, and again in the cycle after
        // the last bit of a word, as long as the frame continues.
        do_load = ((state_q == IDLE) && cs_fall) ||
                  ((state_q == ACTIVE) && load_pend_q && !cs_rise);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            shin_q      <= '0;
            shout_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            cnt_q       <= '0;
            load_pend_q <= 1'b0;
            skip_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;

            // A write needs the register empty and a transfer needs it full,
            // so these two updates never happen in the same cycle.
            if (tx_valid_i && !hold_full_q) begin
                hold_q      <= tx_data_i;
                hold_full_q <= 1'b1;
            end

            if (do_load) begin
                if (hold_full_q) begin
                    shout_q     <= hold_q;
                    hold_full_q <= 1'b0;
                end else begin
                    shout_q    <= '0;
                    underrun_q <= 1'b1;
                end
                // The first bit is already on miso after a load. Any shift
                // edge that comes before the next sample edge must be skipped:
                // always mid-frame, and at frame start only when CPHA=1.
                skip_q      <= (state_q == ACTIVE) || (CPHA != 0);
                load_pend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= ACTIVE;
                        cnt_q   <= '0;
                        shin_q  <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        load_pend_q <= 1'b0;
                        skip_q      <= 1'b0;
                        shout_q     <= '0;
                    end else begin
                        if (sample_edge) begin
                            shin_q <= shin_d;
                            if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                                cnt_q       <= '0;
                                rx_data_q   <= shin_d;
                                rx_valid_q  <= 1'b1;
                                load_pend_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                        if (shift_edge) begin
                            if (skip_q) skip_q  <= 1'b0;
                            else        shout_q <= shout_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = (state_q == ACTIVE);
    assign miso_o     = busy_o & ((MSB_FIRST != 0) ? shout_q[DATA_WIDTH-1] : shout_q[0]);
    assign tx_ready_o = ~hold_full_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_param.sv
module tb_spi_slave_param;
    localparam int HALF = 5;   // SPI half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  sclk = 2'b10;   // dut1 idles high (CPOL=1)
    logic [1:0]  csn  = 2'b11;
    logic [1:0]  mosi = 2'b00;
    logic        miso0, miso1;
    logic [7:0]  tx_data0 = '0;
    logic [15:0] tx_data1 = '0;
    logic        tx_valid0 = 1'b0, tx_valid1 = 1'b0;
    logic        tx_ready0, tx_ready1, rx_valid0, rx_valid1;
    logic        busy0, busy1, underrun0, underrun1;
    logic [7:0]  rx_data0;
    logic [15:0] rx_data1;

    int n_cmp = 0, n_err = 0, ur0 = 0;
    logic [31:0] sb0[$], sb1[$];

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_WIDTH(8)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk[0]), .spi_cs_n_i(csn[0]),
        .mosi_i(mosi[0]), .miso_o(miso0), .tx_data_i(tx_data0), .tx_valid_i(tx_valid0),
        .tx_ready_o(tx_ready0), .rx_data_o(rx_data0), .rx_valid_o(rx_valid0),
        .busy_o(busy0), .underrun_o(underrun0));

    spi_slave_param #(.DATA_WIDTH(16), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk[1]), .spi_cs_n_i(csn[1]),
        .mosi_i(mosi[1]), .miso_o(miso1), .tx_data_i(tx_data1), .tx_valid_i(tx_valid1),
        .tx_ready_o(tx_ready1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1),
        .busy_o(busy1), .underrun_o(underrun1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard drain: every rx_valid strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (rx_valid0) begin
            if (sb0.size() == 0) chk("rx0_unexpected", 32'(rx_data0), 32'hFFFF_FFFF);
            else                 chk("rx0_data", 32'(rx_data0), sb0.pop_front());
        end
        if (rx_valid1) begin
            if (sb1.size() == 0) chk("rx1_unexpected", 32'(rx_data1), 32'hFFFF_FFFF);
            else                 chk("rx1_data", 32'(rx_data1), sb1.pop_front());
        end
        if (underrun0) ur0++;
    end

    function automatic logic miso_of(input int d);
        return (d == 0) ? miso0 : miso1;
    endfunction

    // Drives the SPI master side of DUT d. Returns the bits captured from miso.
    task automatic xfer(input int d, input logic [31:0] tx, input int nbits,
                        output logic [31:0] rx);
        int w, b;
        bit msb, cpol, cpha;
        if (d == 0) begin w = 8;  msb = 1'b1; cpol = 1'b0; cpha = 1'b0; end
        else        begin w = 16; msb = 1'b0; cpol = 1'b1; cpha = 1'b1; end
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            b = msb ? (w - 1 - i) : i;
            if (!cpha) begin
                mosi[d] = tx[b];
                wait_clk(HALF);
                rx[b] = miso_of(d);
                sclk[d] = ~cpol;
                wait_clk(HALF);
                sclk[d] = cpol;
            end else begin
                sclk[d] = ~cpol;
                mosi[d] = tx[b];
                wait_clk(HALF);
                rx[b] = miso_of(d);
                sclk[d] = cpol;
                wait_clk(HALF);
            end
        end
        wait_clk(HALF);
    endtask

    task automatic write_tx(input int d, input logic [31:0] v);
        int t = 0;
        while (((d == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("tx_ready_wait", 32'((d == 0) ? tx_ready0 : tx_ready1), 32'd1);
        if (d == 0) begin tx_data0 = v[7:0];  tx_valid0 = 1'b1; end
        else        begin tx_data1 = v[15:0]; tx_valid1 = 1'b1; end
        @(negedge clk);
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
    endtask

    task automatic cs_set(input int d, input bit v);
        csn[d] = v;
        wait_clk(10);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_miso"},     32'(miso0),      32'd0);
        chk({tag, "_rx_data"},  32'(rx_data0),   32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid0),  32'd0);
        chk({tag, "_busy"},     32'(busy0),      32'd0);
        chk({tag, "_underrun"}, 32'(underrun0),  32'd0);
        chk({tag, "_tx_ready"}, 32'(tx_ready0),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap;
        int ur_base;

        wait_clk(5);
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        wait_clk(5);
        chk_reset_vals("rst_idle");

        // Mode 0: receive 0xCB while transmitting preloaded 0xD2.
        write_tx(0, 32'hD2);
        chk("tx_ready_full", 32'(tx_ready0), 32'd0);
        cs_set(0, 1'b0);
        chk("busy_active", 32'(busy0), 32'd1);
        chk("tx_ready_frame_start", 32'(tx_ready0), 32'd1);
        sb0.push_back(32'hCB);
        xfer(0, 32'hCB, 8, cap);
        chk("miso_D2", cap, 32'hD2);
        cs_set(0, 1'b1);
        chk("busy_idle", 32'(busy0), 32'd0);

        // Back-to-back words within one frame, then an underrun word.
        write_tx(0, 32'h3C);
        cs_set(0, 1'b0);
        ur_base = ur0;
        write_tx(0, 32'hA5);
        sb0.push_back(32'h11);
        xfer(0, 32'h11, 8, cap);
        chk("miso_3C", cap, 32'h3C);
        chk("underrun_none", 32'(ur0 - ur_base), 32'd0);
        sb0.push_back(32'h7E);
        xfer(0, 32'h7E, 8, cap);
        chk("miso_A5", cap, 32'hA5);
        chk("underrun_one", 32'(ur0 - ur_base), 32'd1);
        sb0.push_back(32'h96);
        xfer(0, 32'h96, 8, cap);
        chk("miso_00", cap, 32'h00);
        cs_set(0, 1'b1);

        // Abort after 5 bits, then a full frame.
        cs_set(0, 1'b0);
        xfer(0, 32'h55, 5, cap);
        cs_set(0, 1'b1);
        chk("abort_rx_hold", 32'(rx_data0), 32'h96);
        cs_set(0, 1'b0);
        sb0.push_back(32'hF0);
        xfer(0, 32'hF0, 8, cap);
        cs_set(0, 1'b1);

        // Reset mid-frame after 3 bits. The remainder of the frame is ignored.
        cs_set(0, 1'b0);
        xfer(0, 32'hFF, 3, cap);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("rst_mid");
        xfer(0, 32'hFF, 5, cap);
        chk("rst_busy_stays_low", 32'(busy0), 32'd0);
        cs_set(0, 1'b1);
        cs_set(0, 1'b0);
        sb0.push_back(32'h81);
        xfer(0, 32'h81, 8, cap);
        cs_set(0, 1'b1);

        // Mode 3, 16-bit, LSB first: full duplex.
        write_tx(1, 32'h1234);
        cs_set(1, 1'b0);
        chk("busy1_active", 32'(busy1), 32'd1);
        sb1.push_back(32'hA55A);
        xfer(1, 32'hA55A, 16, cap);
        chk("miso1_1234", cap, 32'h1234);
        cs_set(1, 1'b1);

        wait_clk(20);
        chk("sb0_left", 32'(sb0.size()), 32'd0);
        chk("sb1_left", 32'(sb1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
Name: spi_slave_param

Overview:
- Parametrised SPI slave that oversamples spi_clk, spi_cs_n and mosi on the system clock.
- Supports all four CPOL/CPHA modes, configurable word width and bit order, and chip-select framing.
- Transmit path has a one-word holding register with a valid/ready handshake; receive path emits a one-cycle rx_valid strobe per word.
- Sits between the external SPI master (MCU) and the register/command logic; supersedes the fixed 8-bit mode-0 reader.

Parameters:
- DATA_WIDTH, 8: bits per SPI word (2..32).
- CPOL, 0: spi_clk idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first, 0 = LSB first.
- SYNC_STAGES, 2: synchroniser flops on spi_clk, spi_cs_n and mosi (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- spi_clk  in  1  SPI clock from master (asynchronous)
- spi_cs_n  in  1  chip select, active low (asynchronous)
- mosi  in  1  master-out data (asynchronous)
- miso  out  1  slave-out data
- tx_data  in  DATA_WIDTH  word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding register empty; write accepted when tx_valid&&tx_ready
- rx_data  out  DATA_WIDTH  last complete received word, held until the next word
- rx_valid  out  1  one-cycle pulse, rx_data updated this cycle
- busy  out  1  synchronised cs_n low (frame active)
- underrun  out  1  one-cycle pulse, word loaded while the holding register was empty

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, busy=0, underrun=0, tx_ready=1. Holding register, shift registers and bit counter are cleared; the slave waits for a new cs_n falling edge.
- Synchronisation and edge detection:
  - Each asynchronous input passes through SYNC_STAGES flops.
  - Edges are detected by comparing the last synchroniser stage with one extra delay flop.
  - Leading edge = transition away from CPOL. Trailing edge = transition back to CPOL.
  - Internal reaction occurs SYNC_STAGES+1 clk cycles after the pin edge.
  - Master requirement: spi_clk high and low times >= SYNC_STAGES+2 clk cycles; mosi stable across that window.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE on synchronised cs_n falling edge.
  - ACTIVE -> IDLE on synchronised cs_n rising edge.
  - busy=1 exactly while in ACTIVE.
- Word load occurs on entry to ACTIVE and in the cycle after the last bit of a word is sampled, if cs_n is still low.
  - If the holding register is full: shift-out register <= holding, holding marked empty, tx_ready=1 next cycle.
  - If the holding register is empty: shift-out register <= 0 and underrun pulses.
- miso: driven with the current first bit (MSB or LSB per MSB_FIRST) of shift-out whenever ACTIVE; 0 in IDLE.
- Sample edge (leading if CPHA=0, trailing if CPHA=1):
  - Shift synchronised mosi into shift-in in the configured bit order; bit counter++.
  - When the counter reaches DATA_WIDTH: rx_data <= assembled word, rx_valid=1 for one cycle, counter <= 0, next word loads.
- Shift edge (the opposite edge): advance shift-out by one bit.
  - With CPHA=1, the first leading edge of each word does not shift, because the first bit is already presented at load.
- Holding register:
  - tx_valid&&tx_ready captures tx_data; tx_ready=0 from the next cycle until the word transfers to shift-out.
  - A write and a transfer never coincide: writes require tx_ready=1 and transfers require the register to be full.
- cs_n rises mid-word:
  - Partial word discarded, no rx_valid, counter cleared.
  - Word in shift-out lost; holding register unaffected.
  - Spurious spi_clk edges in IDLE are ignored.
- rst mid-frame: all state cleared immediately; the remainder of the current frame is ignored until cs_n goes high then low again.
- rx has no backpressure; the consumer must take rx_data within DATA_WIDTH SPI bit periods.

Test Plan:
- Mode 0, DATA_WIDTH=8, MSB first: master sends 0xCB in one frame -> exactly one rx_valid pulse, rx_data=0xCB; busy high only while cs_n is low (plus sync delay).
- Mode 0 TX: tx_data=0xD2 written before cs_n falls; master clocks 8 bits -> miso before each rising edge is 1,1,0,1,0,0,1,0; tx_ready returns to 1 at frame start.
- Back-to-back words with cs_n held low: write 0x3C, then 0xA5 once tx_ready rises -> miso streams 0x3C then 0xA5; no underrun. Repeat with no second write -> third word shifts out 0x00 with one underrun pulse.
- Abort: cs_n rises after 5 bits -> no rx_valid. Next full frame sending 0xF0 -> rx_data=0xF0.
- CPOL=1, CPHA=1, DATA_WIDTH=16, MSB_FIRST=0: master sends 0xA55A while slave sends 0x1234 -> rx_data=0xA55A and master captures 0x1234.
- rst pulsed after bit 3 with cs_n still low -> outputs at reset values, no rx_valid for the rest of the frame; a new frame after cs_n toggles sending 0x81 -> rx_data=0x81.
